// File: rtl/md_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// op and state encodings, iteration count and the fixed start-to-done latency.
package md_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_ADJUST = 2'd2,
        ST_DONE   = 2'd3
    } md_state_e;

    localparam int MD_ITERS   = 32;
    localparam int MD_LATENCY = 34;

    function automatic logic op_is_div(input md_op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input md_op_e op);
        return op[2] & op[1];
    endfunction

    function automatic logic rs1_signed(input md_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic rs2_signed(input md_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation: yields |x| when fed a negative
// signed operand, and restores the result sign after the unsigned core.
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle on unsigned magnitudes, sign fixed afterwards.
module md_unit
    import md_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] rs1_val,
    input  logic [DATA_WIDTH-1:0] rs2_val,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  kill,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic                  wb_en
);

    localparam int W = DATA_WIDTH;
    localparam logic [5:0] ITER_LAST = 6'(MD_ITERS - 1);

    md_state_e             state_reg;
    md_op_e                op_reg;
    logic [2*W-1:0]        acc_reg;
    logic [W-1:0]          opnd_reg;
    logic [5:0]            cnt_reg;
    logic                  neg_reg;
    logic                  divzero_reg;
    logic [ADDR_WIDTH-1:0] rd_reg;
    logic [ADDR_WIDTH-1:0] wb_addr_reg;
    logic [W-1:0]          result_reg;
    logic                  done_reg;
    logic                  wb_en_reg;

    md_op_e                op_in;
    logic [W-1:0]          opnd_raw [2];
    logic                  opnd_neg [2];
    logic [W-1:0]          opnd_mag [2];
    logic                  neg_next;

    always_comb begin
        op_in       = md_op_e'(op);
        opnd_raw[0] = rs1_val;
        opnd_raw[1] = rs2_val;
        opnd_neg[0] = rs1_signed(op_in) & rs1_val[W-1];
        opnd_neg[1] = rs2_signed(op_in) & rs2_val[W-1];
        // Remainder follows the dividend; products and quotients follow the sign product.
        neg_next    = op_is_rem(op_in) ? opnd_neg[0] : (opnd_neg[0] ^ opnd_neg[1]);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_abs
            md_sign_fix #(.W(W)) u_abs (
                .value  (opnd_raw[gi]),
                .negate (opnd_neg[gi]),
                .result (opnd_mag[gi])
            );
        end
    endgenerate

    // One iteration of the shared accumulator: low half holds the multiplier
    // or the dividend being shifted out, high half the partial product or remainder.
    logic [W:0]     mul_sum;
    logic [W:0]     div_diff;
    logic [2*W-1:0] acc_next;

    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, opnd_reg} : {(W+1){1'b0}});
        div_diff = acc_reg[2*W-1:W-1] - {1'b0, opnd_reg};
        if (op_is_div(op_reg)) begin
            acc_next = div_diff[W] ? {acc_reg[2*W-2:0], 1'b0}
                                   : {div_diff[W-1:0], acc_reg[W-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc_reg[W-1:1]};
        end
    end

    // Sign correction: full-width negate for products, zero-extended word for quotient/remainder.
    logic [2*W-1:0] adj_src;
    logic [2*W-1:0] adj_out;
    logic [W-1:0]   result_next;

    always_comb begin
        if (!op_is_div(op_reg)) begin
            adj_src = acc_reg;
        end else if (op_is_rem(op_reg)) begin
            adj_src = {{W{1'b0}}, acc_reg[2*W-1:W]};
        end else begin
            adj_src = {{W{1'b0}}, acc_reg[W-1:0]};
        end

        if ((op_reg == OP_MUL) || op_is_div(op_reg)) begin
            result_next = adj_out[W-1:0];
        end else begin
            result_next = adj_out[2*W-1:W];
        end

        // Remainder by zero already equals rs1 after the sign fix; only the quotient needs forcing.
        if (op_is_div(op_reg) && !op_is_rem(op_reg) && divzero_reg) begin
            result_next = {W{1'b1}};
        end
    end

    md_sign_fix #(.W(2*W)) u_adj (
        .value  (adj_src),
        .negate (neg_reg),
        .result (adj_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            op_reg      <= OP_MUL;
            acc_reg     <= '0;
            opnd_reg    <= '0;
            cnt_reg     <= '0;
            neg_reg     <= 1'b0;
            divzero_reg <= 1'b0;
            rd_reg      <= '0;
            wb_addr_reg <= '0;
            result_reg  <= '0;
            done_reg    <= 1'b0;
            wb_en_reg   <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            wb_en_reg <= 1'b0;
            if (kill && (state_reg != ST_IDLE)) begin
                state_reg <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start && !kill) begin
                            op_reg      <= op_in;
                            acc_reg     <= {{W{1'b0}}, opnd_mag[0]};
                            opnd_reg    <= opnd_mag[1];
                            neg_reg     <= neg_next;
                            divzero_reg <= (rs2_val == '0);
                            rd_reg      <= rd_addr;
                            cnt_reg     <= '0;
                            state_reg   <= ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        acc_reg <= acc_next;
                        cnt_reg <= cnt_reg + 6'd1;
                        if (cnt_reg == ITER_LAST) begin
                            state_reg <= ST_ADJUST;
                        end
                    end
                    ST_ADJUST: begin
                        result_reg  <= result_next;
                        wb_addr_reg <= rd_reg;
                        done_reg    <= 1'b1;
                        wb_en_reg   <= (rd_reg != '0);
                        state_reg   <= ST_DONE;
                    end
                    ST_DONE: begin
                        state_reg <= ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy    = (state_reg != ST_IDLE);
    assign done    = done_reg;
    assign wb_en   = wb_en_reg;
    assign result  = result_reg;
    assign wb_addr = wb_addr_reg;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: directed corner cases plus random ops checked
// against a plain-arithmetic RV32M reference, including kill and mid-op reset.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [4:0]  rd_addr = '0;
    logic        kill = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  wb_addr;
    logic        wb_en;

    md_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_addr (rd_addr),
        .kill    (kill),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .wb_addr (wb_addr),
        .wb_en   (wb_en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  addr;
        logic        wen;
        int          cyc;
        logic [2:0]  op;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: RV32M semantics from 64-bit integer arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sbv;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sbv; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sbv; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sbv; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done actual=1 expected=0 result=0x%0h (cycle %0d)", result, cyc);
            end else begin
                mon_e = sb.pop_front();
                $display("txn op=%0d rd=%0d result=0x%08h wb_en=%0b cycle=%0d", mon_e.op, mon_e.addr, result, wb_en, cyc);
                check("result", {32'b0, result}, {32'b0, mon_e.res});
                check("wb_addr", {59'b0, wb_addr}, {59'b0, mon_e.addr});
                check("wb_en", {63'b0, wb_en}, {63'b0, mon_e.wen});
                check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res);
        exp_t e;
        e.res  = exp_res;
        e.addr = rd;
        e.wen  = (rd != 0);
        e.cyc  = cyc + 34;
        e.op   = o;
        sb.push_back(e);
        op = o; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", {63'b0, busy}, 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && busy; i++) tick();
        check("idle_timeout", {63'b0, busy}, 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {63'b0, busy}, 64'd0);
        check({tag, "_done"}, {63'b0, done}, 64'd0);
        check({tag, "_wb_en"}, {63'b0, wb_en}, 64'd0);
        check({tag, "_result"}, {32'b0, result}, 64'd0);
        check({tag, "_wb_addr"}, {59'b0, wb_addr}, 64'd0);
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] r;
    } dir_t;

    dir_t dirs[$] = '{
        '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB},
        '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000},
        '{3'd3, 32'h8000_0000,  32'h8000_0000, 5'd2,  32'h4000_0000},
        '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF},
        '{3'd5, 32'd100,        32'd0,         5'd4,  32'hFFFF_FFFF},
        '{3'd7, 32'd100,        32'd0,         5'd6,  32'd100},
        '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd7,  32'h8000_0000},
        '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8,  32'h0},
        '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFF},
        '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFD},
        '{3'd4, 32'hFFFF_FFF9,  32'd0,         5'd11, 32'hFFFF_FFFF},
        '{3'd6, 32'hFFFF_FFF9,  32'd0,         5'd12, 32'hFFFF_FFF9}
    };

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        exp_t        dropped;
        logic [31:0] a, b;
        logic [2:0]  o;
        logic [4:0]  rd;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;
        tick();

        foreach (dirs[i]) begin
            issue(dirs[i].o, dirs[i].a, dirs[i].b, dirs[i].rd, dirs[i].r);
            wait_idle();
        end

        // rd=0 still signals done; a second start mid-operation must be dropped.
        issue(3'd0, 32'd3, 32'd5, 5'd0, 32'd15);
        repeat (9) tick();
        op = 3'd4; rs1_val = 32'd9; rs2_val = 32'd3; rd_addr = 5'd13; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        repeat (3) tick();

        // kill at relative cycle 10: idle next cycle, never a done.
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14, 32'h0);
        dropped = sb.pop_back();
        repeat (9) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_busy", {63'b0, busy}, 64'd0);
        check("kill_done", {63'b0, done}, 64'd0);
        repeat (40) tick();

        // Reset at relative cycle 20 for two cycles, then a fresh op.
        issue(3'd6, 32'd1000, 32'd7, 5'd15, 32'h0);
        dropped = sb.pop_back();
        repeat (19) tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        issue(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd16, ref_md(3'd4, 32'hFFFF_FF9C, 32'd7));
        wait_idle();

        for (int n = 0; n < 60; n++) begin
            o  = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom_range(0, 31));
            issue(o, a, b, rd, ref_md(o, a, b));
            wait_idle();
        end

        repeat (5) tick();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result width.
REQ-002 Parameter ADDR_WIDTH, default 5, register-file address width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk is the sole clock; rst_n asynchronously resets all state when low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a new operation; accepted only in IDLE.
REQ-007 op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 rs1_val  input  DATA_WIDTH  operand A, taken from register-file RD1.
REQ-009 rs2_val  input  DATA_WIDTH  operand B, taken from register-file RD2.
REQ-010 rd_addr  input  ADDR_WIDTH  destination register.
REQ-011 kill  input  1  synchronous abort of the in-flight operation.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 done  output  1  one-cycle pulse marking a valid result.
REQ-014 result  output  DATA_WIDTH  result, driven to register-file WD3.
REQ-015 wb_addr  output  ADDR_WIDTH  write-back address, driven to A3.
REQ-016 wb_en  output  1  write enable, driven to WE3.

Function
REQ-017 FSM states SHALL be IDLE, CALC, ADJUST and DONE.
REQ-018 IDLE->CALC SHALL occur on an edge with start=1; op, magnitudes of the operands, operand signs and rd_addr are captured on that edge, and the iteration counter is cleared.
REQ-019 CALC SHALL perform exactly 32 iterations, one per edge: shift-add for multiply, restoring shift-subtract for divide; the 32nd iteration moves to ADJUST.
REQ-020 ADJUST SHALL apply the sign correction and the special-case overrides, then move to DONE.
REQ-021 In DONE, done=1 and wb_en=(wb_addr!=0) for exactly one cycle; the next state is IDLE.
REQ-022 Latency SHALL be fixed for every op: start high in cycle k gives done high in cycle k+34.
REQ-023 start SHALL be ignored while busy=1; no queuing.
REQ-024 Multiply SHALL form the full 64-bit product. MUL returns the low 32 bits; MULH, MULHSU and MULHU return the high 32 bits. Operand signedness is: MULH s*s, MULHSU s*u, MULHU u*u.
REQ-025 DIV and REM SHALL be signed, with the quotient truncated toward zero and the remainder taking the sign of the dividend. DIVU and REMU SHALL be unsigned.
REQ-026 Divide by zero: the quotient SHALL be all ones and the remainder SHALL equal rs1_val, for both signed and unsigned forms.
REQ-027 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-028 rd_addr=0: the operation SHALL complete with done=1, but wb_en SHALL stay 0.
REQ-029 kill=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge with no done and no wb_en. kill SHALL take priority over start and over the DONE transition.
REQ-030 result and wb_addr SHALL hold their values outside DONE; consumers SHALL qualify them with done and wb_en.

Reset
REQ-031 While rst_n=0, the FSM SHALL be in IDLE, and busy, done, wb_en, result, wb_addr, the counter and all datapath registers SHALL be 0, regardless of clk.
REQ-032 Reset asserted mid-operation SHALL discard the operation. The first edge after release SHALL be treated as IDLE.

Structure
REQ-033 Shared package md_pkg SHALL hold the op encodings, the FSM state encoding, MD_ITERS=32 and MD_LATENCY=34.
REQ-034 One combinational sub-module, md_sign_fix, SHALL perform operand absolute value and conditional two's-complement negation, and SHALL be used at both capture and ADJUST.
REQ-035 The iterative datapath SHALL be a single 64-bit accumulator plus a 32-bit divisor/multiplicand register; no hardware multiplier is inferred.

Verification
REQ-036 MUL 7 * 0xFFFFFFFD, rd=5, start in cycle 0 -> done and wb_en in cycle 34, result 0xFFFFFFEB, wb_addr 5.
REQ-037 MULH 0x80000000 * 0x80000000 -> 0x40000000. MULHU with the same operands -> 0x40000000. MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-038 DIVU 100 / 0 -> 0xFFFFFFFF. REMU 100 % 0 -> 100. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
REQ-039 REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
REQ-040 MUL with rd=0 -> done=1 in cycle 34 and wb_en=0. A second start at cycle 10 -> ignored, with only one done observed.
REQ-041 kill asserted in cycle 10 -> busy=0 from cycle 11 and no done. Separately, rst_n low in cycle 20 for 2 cycles -> all outputs 0, and a new start after release gives a correct result 34 cycles later.
